// File: rtl/clock_controller_pkg.sv
// Shared types and constants for the digital-clock controller: the state
// encoding (also driven out on `mode` for the display/blink logic) and the
// bit index of each time field in the add_time/sub_time strobes.
package clock_controller_pkg;

   localparam int MODE_W  = 3;
   localparam int FIELD_W = 3;

   // Field bit indices inside add_time / sub_time.
   localparam int SEC  = 0;
   localparam int MIN  = 1;
   localparam int HOUR = 2;

   typedef enum logic [MODE_W-1:0] {
      OFF      = 3'd0,
      RUN      = 3'd1,
      SET_SEC  = 3'd2,
      SET_MIN  = 3'd3,
      SET_HOUR = 3'd4
   } state_t;

   // One-hot field selected by a time-setting state; zero in OFF and RUN.
   function automatic logic [FIELD_W-1:0] field_sel(input state_t s);
      logic [FIELD_W-1:0] r;
      r = '0;
      case (s)
         SET_SEC:  r[SEC]  = 1'b1;
         SET_MIN:  r[MIN]  = 1'b1;
         SET_HOUR: r[HOUR] = 1'b1;
         default:  r = '0;
      endcase
      return r;
   endfunction

   // True for the three time-setting states.
   function automatic logic is_set(input state_t s);
      return (s == SET_SEC) || (s == SET_MIN) || (s == SET_HOUR);
   endfunction

endpackage

// File: rtl/clock_controller_if.sv
// Signal bundle between the button/timer side of the clock and the
// controller. All strobes are single-cycle, level-sampled on the rising
// clock edge; there is no back-pressure, so a strobe that is high for one
// cycle is consumed by the receiving timer in that same cycle.
interface clock_controller_if;
   import clock_controller_pkg::*;

   logic               power;
   logic               tick;
   logic               btn_mode;
   logic               btn_add;
   logic               btn_sub;
   logic               sec_end;
   logic               min_end;
   logic               timer_reset;
   logic               sec_en;
   logic               min_en;
   logic               hour_en;
   logic [FIELD_W-1:0] add_time;
   logic [FIELD_W-1:0] sub_time;
   logic [MODE_W-1:0]  mode;

   // Controller side.
   modport slave (
      input  power, tick, btn_mode, btn_add, btn_sub, sec_end, min_end,
      output timer_reset, sec_en, min_en, hour_en, add_time, sub_time, mode
   );

   // Button/timer side.
   modport master (
      output power, tick, btn_mode, btn_add, btn_sub, sec_end, min_end,
      input  timer_reset, sec_en, min_en, hour_en, add_time, sub_time, mode
   );

endinterface

// File: rtl/clock_controller_btn_pulse.sv
// Button front end: registers a level button, emits a one-cycle pulse on
// the first sampled press and, when REPEAT_EN is set, keeps emitting pulses
// every REPEAT_RATE cycles once the button has been held REPEAT_DELAY
// cycles. The pulse appears in the cycle after the first edge that samples
// the button high.
module clock_controller_btn_pulse #(
   parameter bit REPEAT_EN    = 1'b1,
   parameter int REPEAT_DELAY = 50,
   parameter int REPEAT_RATE  = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic pulse
);

   localparam int CNT_W = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
   localparam logic [CNT_W-1:0] DELAY_V = CNT_W'(REPEAT_DELAY);
   // Once past the initial delay the counter loops DELAY..DELAY+RATE-1, so
   // it hits DELAY_V again every REPEAT_RATE cycles.
   localparam logic [CNT_W-1:0] WRAP_V  = CNT_W'(REPEAT_DELAY + REPEAT_RATE - 1);

   logic             btn_q;
   logic             btn_prev;
   logic [CNT_W-1:0] hold_cnt;
   logic             press_edge;
   logic             repeat_hit;

   // Button sampling, edge history and hold-time counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_q    <= 1'b0;
         btn_prev <= 1'b0;
         hold_cnt <= '0;
      end else begin
         btn_q    <= btn;
         btn_prev <= btn_q;
         if (!btn_q || !REPEAT_EN) begin
            hold_cnt <= '0;
         end else if (hold_cnt == WRAP_V) begin
            hold_cnt <= DELAY_V;
         end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
         end
      end
   end

   // First-press pulse plus auto-repeat pulses while held.
   always_comb begin
      press_edge = btn_q & ~btn_prev;
      repeat_hit = REPEAT_EN & btn_q & (hold_cnt == DELAY_V);
      pulse      = press_edge | repeat_hit;
   end

endmodule

// File: rtl/clock_controller.sv
// Digital-clock sequencer: turns power/mode/add/sub buttons into strobes
// for the sec/min/hour timers, chains carries sec -> min -> hour while
// running, and runs the time-setting mode FSM with auto-repeat and an
// inactivity timeout back to RUN.
module clock_controller #(
   parameter int REPEAT_DELAY = 50,
   parameter int REPEAT_RATE  = 10,
   parameter int TIMEOUT      = 30
) (
   input  logic              clk_normal,
   input  logic              reset,
   clock_controller_if.slave bus
);
   import clock_controller_pkg::*;

   localparam int TO_W = $clog2(TIMEOUT + 1);
   localparam logic [TO_W-1:0] TIMEOUT_V = TO_W'(TIMEOUT);

   state_t             state_q;
   state_t             state_d;
   logic               timer_reset_q;
   logic [TO_W-1:0]    to_cnt;
   logic               timeout_hit;
   logic               mode_p;
   logic               add_p;
   logic               sub_p;
   logic               any_p;
   logic               add_ok;
   logic               sub_ok;
   logic [FIELD_W-1:0] field;

   clock_controller_btn_pulse #(
      .REPEAT_EN   (1'b0),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
   ) u_mode_btn (
      .clk  (clk_normal),
      .rst  (reset),
      .btn  (bus.btn_mode),
      .pulse(mode_p)
   );

   clock_controller_btn_pulse #(
      .REPEAT_EN   (1'b1),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
   ) u_add_btn (
      .clk  (clk_normal),
      .rst  (reset),
      .btn  (bus.btn_add),
      .pulse(add_p)
   );

   clock_controller_btn_pulse #(
      .REPEAT_EN   (1'b1),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
   ) u_sub_btn (
      .clk  (clk_normal),
      .rst  (reset),
      .btn  (bus.btn_sub),
      .pulse(sub_p)
   );

   // Qualified pulses: add and sub cancel each other, a mode step beats
   // both, and nothing edits time while power is off.
   always_comb begin
      any_p       = mode_p | add_p | sub_p;
      add_ok      = bus.power & add_p & ~sub_p & ~mode_p;
      sub_ok      = bus.power & sub_p & ~add_p & ~mode_p;
      timeout_hit = (to_cnt == TIMEOUT_V);
      field       = field_sel(state_q);
   end

   // State register; timer_reset is registered from the next state so it
   // always matches (state == OFF).
   always_ff @(posedge clk_normal or posedge reset) begin
      if (reset) begin
         state_q       <= OFF;
         timer_reset_q <= 1'b1;
      end else begin
         state_q       <= state_d;
         timer_reset_q <= (state_d == OFF);
      end
   end

   // Next-state logic; power-off overrides every button.
   always_comb begin
      state_d = state_q;
      if (!bus.power) begin
         state_d = OFF;
      end else begin
         case (state_q)
            OFF:      state_d = RUN;
            RUN:      if (mode_p) state_d = SET_SEC;
            SET_SEC:  if (mode_p) state_d = SET_MIN;
                      else if (timeout_hit) state_d = RUN;
            SET_MIN:  if (mode_p) state_d = SET_HOUR;
                      else if (timeout_hit) state_d = RUN;
            SET_HOUR: if (mode_p) state_d = RUN;
                      else if (timeout_hit) state_d = RUN;
            default:  state_d = OFF;
         endcase
      end
   end

   // Inactivity counter: counts ticks while a SET state is held, cleared by
   // any button pulse or state change, saturating at TIMEOUT.
   always_ff @(posedge clk_normal or posedge reset) begin
      if (reset) begin
         to_cnt <= '0;
      end else if (!is_set(state_d) || (state_d != state_q) || any_p) begin
         to_cnt <= '0;
      end else if (bus.tick && !timeout_hit) begin
         to_cnt <= to_cnt + TO_W'(1);
      end
   end

   // Timer strobes: carry chain in RUN, per-field add/sub in SET states.
   always_comb begin
      bus.sec_en   = 1'b0;
      bus.min_en   = 1'b0;
      bus.hour_en  = 1'b0;
      bus.add_time = '0;
      bus.sub_time = '0;
      if (state_q == RUN) begin
         bus.sec_en  = bus.tick;
         bus.min_en  = bus.tick & bus.sec_end;
         bus.hour_en = bus.tick & bus.sec_end & bus.min_end;
      end
      bus.add_time = field & {FIELD_W{add_ok}};
      bus.sub_time = field & {FIELD_W{sub_ok}};
   end

   assign bus.timer_reset = timer_reset_q;
   assign bus.mode        = state_q;

endmodule
